cascade_scheduler: RTL and testbench

- Frame-level controller that sequences the sliding-window detector.
- Consumes window origins (x,y) from the hopper over a valid/ready handshake.
- For each window it requests an integral-window load, then runs the cascade stages one at a time, exiting early on the first stage reject.
- Reports detected windows downstream and signals end-of-frame after exactly one full sweep.

---
 rtl/cascade_scheduler.sv | 176 +++++++++++++++++
 tb/tb_cascade_scheduler.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cascade_scheduler.sv
// rtl/cascade_scheduler.sv - frame sequencer for the sliding-window detector
// Accepts window origins, requests window loads, walks cascade stages with early exit, reports detections.
module cascade_scheduler #(
    parameter int IMG_WIDTH  = 41,
    parameter int IMG_HEIGHT = 50,
    parameter int SWEEP_X    = 24,
    parameter int SWEEP_Y    = 24,
    parameter int NUM_STAGES = 25,
    localparam int X_BOUNDARY  = IMG_WIDTH - SWEEP_X,
    localparam int Y_BOUNDARY  = IMG_HEIGHT - SWEEP_Y,
    localparam int NUM_WINDOWS = X_BOUNDARY * Y_BOUNDARY,
    localparam int W_X = $clog2(IMG_WIDTH),
    localparam int W_Y = $clog2(IMG_HEIGHT),
    localparam int W_S = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int W_C = $clog2(NUM_WINDOWS + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           frame_done,
    input  logic           hop_valid,
    output logic           hop_ready,
    input  logic [W_X-1:0] x_hop,
    input  logic [W_Y-1:0] y_hop,
    output logic           load_req,
    output logic [W_X-1:0] load_x,
    output logic [W_Y-1:0] load_y,
    input  logic           load_done,
    output logic           stage_start,
    output logic [W_S-1:0] stage_idx,
    input  logic           stage_done,
    input  logic           stage_pass,
    output logic           det_valid,
    input  logic           det_ready,
    output logic [W_X-1:0] det_x,
    output logic [W_Y-1:0] det_y,
    output logic [W_C-1:0] det_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOP,
        S_LOAD,
        S_STAGE_START,
        S_STAGE_WAIT,
        S_REPORT,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [W_C-1:0] LAST_WIN   = W_C'(NUM_WINDOWS - 1);
    localparam logic [W_S-1:0] LAST_STAGE = W_S'(NUM_STAGES - 1);

    state_t         state_q, state_d;
    logic [W_C-1:0] win_cnt_q, win_cnt_d;
    logic [W_C-1:0] det_count_q, det_count_d;
    logic [W_S-1:0] stage_idx_q, stage_idx_d;
    logic [W_X-1:0] load_x_q, load_x_d;
    logic [W_Y-1:0] load_y_q, load_y_d;
    logic [W_X-1:0] det_x_q, det_x_d;
    logic [W_Y-1:0] det_y_q, det_y_d;
    logic           load_req_q, load_req_d;

    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        det_count_d = det_count_q;
        stage_idx_d = stage_idx_q;
        load_x_d    = load_x_q;
        load_y_d    = load_y_q;
        det_x_d     = det_x_q;
        det_y_d     = det_y_q;
        load_req_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_HOP;
                    win_cnt_d   = '0;
                    det_count_d = '0;
                end
            end
            S_HOP: begin
                // hop_ready is decoded from S_HOP, so leaving the state consumes exactly one origin
                if (hop_valid) begin
                    load_x_d   = x_hop;
                    load_y_d   = y_hop;
                    load_req_d = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_done) begin
                    stage_idx_d = '0;
                    state_d     = S_STAGE_START;
                end
            end
            S_STAGE_START: begin
                state_d = S_STAGE_WAIT;
            end
            S_STAGE_WAIT: begin
                if (stage_done) begin
                    if (!stage_pass) begin
                        state_d = S_NEXT;
                    end else if (stage_idx_q == LAST_STAGE) begin
                        det_x_d = load_x_q;
                        det_y_d = load_y_q;
                        state_d = S_REPORT;
                    end else begin
                        stage_idx_d = stage_idx_q + 1'b1;
                        state_d     = S_STAGE_START;
                    end
                end
            end
            S_REPORT: begin
                if (det_ready) begin
                    if (det_count_q != '1) det_count_d = det_count_q + 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (win_cnt_q == LAST_WIN) begin
                    state_d = S_DONE;
                end else begin
                    win_cnt_d = win_cnt_q + 1'b1;
                    state_d   = S_HOP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            win_cnt_q   <= '0;
            det_count_q <= '0;
            stage_idx_q <= '0;
            load_x_q    <= '0;
            load_y_q    <= '0;
            det_x_q     <= '0;
            det_y_q     <= '0;
            load_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            det_count_q <= det_count_d;
            stage_idx_q <= stage_idx_d;
            load_x_q    <= load_x_d;
            load_y_q    <= load_y_d;
            det_x_q     <= det_x_d;
            det_y_q     <= det_y_d;
            load_req_q  <= load_req_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign hop_ready   = (state_q == S_HOP);
    assign stage_start = (state_q == S_STAGE_START);
    assign det_valid   = (state_q == S_REPORT);
    assign frame_done  = (state_q == S_DONE);
    assign load_req    = load_req_q;
    assign load_x      = load_x_q;
    assign load_y      = load_y_q;
    assign stage_idx   = stage_idx_q;
    assign det_x       = det_x_q;
    assign det_y       = det_y_q;
    assign det_count   = det_count_q;

endmodule

// File: tb/tb_cascade_scheduler.sv
// tb/tb_cascade_scheduler.sv - randomized bench for cascade_scheduler against a frame-level reference model
module tb_cascade_scheduler;

    localparam int IMG_W  = 27;
    localparam int IMG_H  = 26;
    localparam int SW_X   = 24;
    localparam int SW_Y   = 24;
    localparam int NS     = 3;
    localparam int XB     = IMG_W - SW_X;
    localparam int YB     = IMG_H - SW_Y;
    localparam int NW     = XB * YB;
    localparam int W_X    = $clog2(IMG_W);
    localparam int W_Y    = $clog2(IMG_H);
    localparam int W_S    = (NS > 1) ? $clog2(NS) : 1;
    localparam int W_C    = $clog2(NW + 1);
    localparam int DC_MAX = (1 << W_C) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           busy;
    logic           frame_done;
    logic           hop_valid;
    logic           hop_ready;
    logic [W_X-1:0] x_hop;
    logic [W_Y-1:0] y_hop;
    logic           load_req;
    logic [W_X-1:0] load_x;
    logic [W_Y-1:0] load_y;
    logic           load_done;
    logic           stage_start;
    logic [W_S-1:0] stage_idx;
    logic           stage_done;
    logic           stage_pass;
    logic           det_valid;
    logic           det_ready;
    logic [W_X-1:0] det_x;
    logic [W_Y-1:0] det_y;
    logic [W_C-1:0] det_count;

    cascade_scheduler #(
        .IMG_WIDTH (IMG_W),
        .IMG_HEIGHT(IMG_H),
        .SWEEP_X   (SW_X),
        .SWEEP_Y   (SW_Y),
        .NUM_STAGES(NS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .hop_valid  (hop_valid),
        .hop_ready  (hop_ready),
        .x_hop      (x_hop),
        .y_hop      (y_hop),
        .load_req   (load_req),
        .load_x     (load_x),
        .load_y     (load_y),
        .load_done  (load_done),
        .stage_start(stage_start),
        .stage_idx  (stage_idx),
        .stage_done (stage_done),
        .stage_pass (stage_pass),
        .det_valid  (det_valid),
        .det_ready  (det_ready),
        .det_x      (det_x),
        .det_y      (det_y),
        .det_count  (det_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // environment state: hopper, load/stage responders, downstream sink
    int hx, hy, load_cnt, stage_cnt, dwait, dlen, held_x, held_y, cur_win;
    bit adv, load_pend, stage_pend, det_prev, acc_prev, fd_prev;
    bit go_req, auto_restart, noise_hop, noise_start, hold_mode;
    int depth [NW];
    int lv_hx[$], lv_hy[$], lv_idx[$], lv_dx[$], lv_dy[$];
    int sn_hx[$], sn_hy[$], sn_idx[$], sn_dx[$], sn_dy[$];
    int lv_nload, sn_nload, sn_dc, frames_done, frames_expected;

    // reference expectations for the current frame
    int e_hx[$], e_hy[$], e_idx[$], e_dx[$], e_dy[$];
    int e_dc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},        32'(busy),        0);
        check({tag, "_hop_ready"},   32'(hop_ready),   0);
        check({tag, "_load_req"},    32'(load_req),    0);
        check({tag, "_stage_start"}, 32'(stage_start), 0);
        check({tag, "_det_valid"},   32'(det_valid),   0);
        check({tag, "_frame_done"},  32'(frame_done),  0);
        check({tag, "_load_x"},      32'(load_x),      0);
        check({tag, "_load_y"},      32'(load_y),      0);
        check({tag, "_stage_idx"},   32'(stage_idx),   0);
        check({tag, "_det_x"},       32'(det_x),       0);
        check({tag, "_det_y"},       32'(det_y),       0);
        check({tag, "_det_count"},   32'(det_count),   0);
    endtask

    // depth[w] = number of leading stages that pass for window w (>= NS means detected)
    task automatic prep_frame();
        int ndet = 0;
        e_hx.delete(); e_hy.delete(); e_idx.delete(); e_dx.delete(); e_dy.delete();
        for (int y = 0; y < YB; y++) begin
            for (int x = 0; x < XB; x++) begin
                int w = y * XB + x;
                e_hx.push_back(x);
                e_hy.push_back(y);
                for (int s = 0; s < NS && s <= depth[w]; s++) e_idx.push_back(s);
                if (depth[w] >= NS) begin
                    e_dx.push_back(x);
                    e_dy.push_back(y);
                    ndet++;
                end
            end
        end
        e_dc = (ndet > DC_MAX) ? DC_MAX : ndet;
    endtask

    task automatic random_depths(input int max_depth);
        for (int w = 0; w < NW; w++) depth[w] = int'($urandom_range(0, max_depth));
    endtask

    task automatic finish_frame(input string tag);
        bit ok = 1'b0;
        frames_expected++;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (frames_done >= frames_expected) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_frame_done_seen"}, 32'(ok), 1);
        if (!ok) return;
        check({tag, "_hop_count"}, sn_hx.size(), e_hx.size());
        for (int i = 0; i < e_hx.size() && i < sn_hx.size(); i++)
            check($sformatf("%s_hop%0d_xy", tag, i), sn_hx[i] * 256 + sn_hy[i], e_hx[i] * 256 + e_hy[i]);
        check({tag, "_load_reqs"}, sn_nload, NW);
        check({tag, "_stage_count"}, sn_idx.size(), e_idx.size());
        for (int i = 0; i < e_idx.size() && i < sn_idx.size(); i++)
            check($sformatf("%s_stage%0d_idx", tag, i), sn_idx[i], e_idx[i]);
        check({tag, "_det_total"}, sn_dx.size(), e_dx.size());
        for (int i = 0; i < e_dx.size() && i < sn_dx.size(); i++)
            check($sformatf("%s_det%0d_xy", tag, i), sn_dx[i] * 256 + sn_dy[i], e_dx[i] * 256 + e_dy[i]);
        check({tag, "_det_count"}, sn_dc, e_dc);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            load_done  = 1'b0;
            stage_done = 1'b0;
            stage_pass = 1'($urandom_range(0, 1));
            start      = 1'b0;
            if (!rst_n) begin
                hx = 0; hy = 0; adv = 0; load_pend = 0; stage_pend = 0;
                det_prev = 0; acc_prev = 0; fd_prev = 0; dwait = 0;
                hop_valid = 1'b0; det_ready = 1'b0; x_hop = '0; y_hop = '0;
                lv_hx.delete(); lv_hy.delete(); lv_idx.delete(); lv_dx.delete(); lv_dy.delete();
                lv_nload = 0;
            end else begin
                if (go_req) begin
                    start  = 1'b1;
                    go_req = 1'b0;
                end else if (noise_start && busy) begin
                    start = 1'($urandom_range(0, 1));
                end

                if (adv) begin
                    adv = 1'b0;
                    if (hx == XB - 1) begin
                        hx = 0;
                        hy = (hy == YB - 1) ? 0 : hy + 1;
                    end else begin
                        hx++;
                    end
                end
                hop_valid = ($urandom_range(0, 3) != 0);
                x_hop = W_X'(hx);
                y_hop = W_Y'(hy);
                if (hop_valid && hop_ready) begin
                    lv_hx.push_back(hx);
                    lv_hy.push_back(hy);
                    adv = 1'b1;
                end

                if (load_req) begin
                    lv_nload++;
                    load_pend = 1'b1;
                    load_cnt  = int'($urandom_range(0, 2));
                end
                if (load_pend) begin
                    if (load_cnt == 0) begin
                        load_done = 1'b1;
                        load_pend = 1'b0;
                    end else begin
                        load_cnt--;
                    end
                end

                if (stage_start) begin
                    lv_idx.push_back(int'(stage_idx));
                    stage_pend = 1'b1;
                    stage_cnt  = int'($urandom_range(1, 3));
                end
                if (stage_pend) begin
                    if (stage_cnt == 0) begin
                        cur_win    = int'(load_y) * XB + int'(load_x);
                        stage_done = 1'b1;
                        stage_pass = (cur_win < NW) && (depth[cur_win] > int'(stage_idx));
                        stage_pend = 1'b0;
                    end else begin
                        stage_cnt--;
                    end
                end

                if (noise_hop && hop_ready && !load_pend && !stage_pend) begin
                    load_done  = 1'($urandom_range(0, 1));
                    stage_done = 1'($urandom_range(0, 1));
                    stage_pass = 1'b1;
                end

                if (acc_prev) check("det_drop_after_accept", 32'(det_valid), 0);
                acc_prev = 1'b0;
                if (det_valid) begin
                    if (!det_prev) begin
                        held_x = int'(det_x);
                        held_y = int'(det_y);
                        dwait  = 0;
                        dlen   = hold_mode ? 10 : int'($urandom_range(0, 2));
                    end else begin
                        check("det_x_stable", 32'(det_x), held_x);
                        check("det_y_stable", 32'(det_y), held_y);
                    end
                    check("det_no_hop_ready", 32'(hop_ready), 0);
                    det_ready = (dwait >= dlen);
                    dwait++;
                    if (det_ready) begin
                        lv_dx.push_back(int'(det_x));
                        lv_dy.push_back(int'(det_y));
                        if (hold_mode) check("det_hold_cycles", dwait, 11);
                        acc_prev = 1'b1;
                    end
                    det_prev = !det_ready;
                end else begin
                    det_ready = 1'($urandom_range(0, 1));
                    det_prev  = 1'b0;
                end

                if (fd_prev) check("frame_done_one_cycle", 32'(frame_done), 0);
                fd_prev = frame_done;
                if (frame_done) begin
                    sn_hx = lv_hx; sn_hy = lv_hy; sn_idx = lv_idx; sn_dx = lv_dx; sn_dy = lv_dy;
                    sn_nload = lv_nload;
                    sn_dc    = int'(det_count);
                    lv_hx.delete(); lv_hy.delete(); lv_idx.delete(); lv_dx.delete(); lv_dy.delete();
                    lv_nload = 0;
                    frames_done++;
                    if (auto_restart) begin
                        go_req       = 1'b1;
                        auto_restart = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        bit found;
        rst_n = 1'b0; start = 1'b0; hop_valid = 1'b0; x_hop = '0; y_hop = '0;
        load_done = 1'b0; stage_done = 1'b0; stage_pass = 1'b0; det_ready = 1'b0;
        go_req = 0; auto_restart = 0; noise_hop = 0; noise_start = 0; hold_mode = 0;
        frames_done = 0; frames_expected = 0; lv_nload = 0;
        for (int w = 0; w < NW; w++) depth[w] = 0;

        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        #1 rst_n = 1'b1;

        // every window rejected at stage 0
        prep_frame();
        go_req = 1'b1;
        finish_frame("all_reject");
        @(posedge clk); #1;
        check("idle_after_frame_busy", 32'(busy), 0);
        check("idle_after_frame_det_count", 32'(det_count), 0);

        // only window (1,1) passes every stage
        for (int w = 0; w < NW; w++) depth[w] = 0;
        depth[1 * XB + 1] = NS;
        prep_frame();
        go_req = 1'b1;
        finish_frame("single_det");

        // long downstream stall on a single detection, with stray starts
        random_depths(NS - 1);
        depth[2] = NS;
        hold_mode = 1'b1; noise_start = 1'b1;
        prep_frame();
        go_req = 1'b1;
        finish_frame("det_hold");
        hold_mode = 1'b0;

        // stray load_done/stage_done in HOP and stray starts while busy
        random_depths(NS);
        noise_hop = 1'b1;
        prep_frame();
        go_req = 1'b1;
        finish_frame("noise");
        noise_hop = 1'b0; noise_start = 1'b0;

        for (int f = 0; f < 4; f++) begin
            random_depths(NS);
            prep_frame();
            go_req = 1'b1;
            finish_frame($sformatf("rand%0d", f));
        end

        // reset while window 3 awaits a stage result
        random_depths(NS - 1);
        depth[0] = NS;
        prep_frame();
        go_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (lv_hx.size() == 4 && stage_start) begin
                found = 1'b1;
                break;
            end
        end
        check("midframe_wait_found", 32'(found), 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 check_idle_outputs("midframe_reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        random_depths(NS);
        prep_frame();
        go_req = 1'b1;
        finish_frame("after_reset");

        // back-to-back frames, restart the cycle after frame_done
        random_depths(NS - 1);
        depth[5] = NS;
        auto_restart = 1'b1;
        prep_frame();
        go_req = 1'b1;
        finish_frame("b2b_first");
        random_depths(NS - 1);
        prep_frame();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy) begin
                found = 1'b1;
                break;
            end
        end
        check("b2b_second_started", 32'(found), 1);
        check("b2b_det_count_cleared", 32'(det_count), 0);
        finish_frame("b2b_second");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
